// File: rtl/common_issue_queue_if.sv
// Entry format shared by dispatch, the issue queue and the execution units,
// plus the dispatch/CDB/issue bundle seen by one issue queue instance.
package common_issue_queue_pkg;

  typedef struct packed {
    logic        wb_valid;
    logic [5:0]  rd_tag;
    logic [5:0]  rs1_tag;
    logic [31:0] rs1_data;
    logic        rs1_data_valid;
    logic [5:0]  rs2_tag;
    logic [31:0] rs2_data;
    logic        rs2_data_valid;
  } common_fifo_data_t;

endpackage

interface common_issue_queue_if;
  import common_issue_queue_pkg::*;

  logic              dispatch_en;
  common_fifo_data_t i_fifo_data;
  logic              queue_full;
  logic              queue_empty;
  logic              cdb_valid;
  logic [5:0]        cdb_tag;
  logic [31:0]       cdb_data;
  logic              exec_ready;
  logic              issue_valid;
  common_fifo_data_t o_issue_data;

  // master: dispatch/CDB/execution side; slave: the issue queue itself
  modport master (
    output dispatch_en, i_fifo_data, cdb_valid, cdb_tag, cdb_data, exec_ready,
    input  queue_full, queue_empty, issue_valid, o_issue_data
  );

  modport slave (
    input  dispatch_en, i_fifo_data, cdb_valid, cdb_tag, cdb_data, exec_ready,
    output queue_full, queue_empty, issue_valid, o_issue_data
  );

endinterface

// File: rtl/common_issue_queue.sv
// In-order issue queue: enqueues dispatched entries, wakes pending operands from
// the CDB, and issues the head entry once both of its operands are valid.
module common_issue_queue
  import common_issue_queue_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  common_issue_queue_if.slave   iq_if
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  common_fifo_data_t entries_q [DEPTH];
  common_fifo_data_t entries_d [DEPTH];
  common_fifo_data_t snooped   [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  logic              full, empty, push, pop;
  common_fifo_data_t head;

  // Fill any still-pending operand whose tag matches the current broadcast.
  function automatic common_fifo_data_t snoop(input common_fifo_data_t e,
                                              input logic              v,
                                              input logic [5:0]        t,
                                              input logic [31:0]       d);
    common_fifo_data_t r;
    r = e;
    if (v && !e.rs1_data_valid && (e.rs1_tag == t)) begin
      r.rs1_data       = d;
      r.rs1_data_valid = 1'b1;
    end
    if (v && !e.rs2_data_valid && (e.rs2_tag == t)) begin
      r.rs2_data       = d;
      r.rs2_data_valid = 1'b1;
    end
    return r;
  endfunction

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign head  = entries_q[rd_ptr_q];

  assign iq_if.queue_full   = full;
  assign iq_if.queue_empty  = empty;
  assign iq_if.issue_valid  = !empty && head.rs1_data_valid && head.rs2_data_valid;
  assign iq_if.o_issue_data = empty ? '0 : head;

  // Full is judged on the current count, so a pop never makes room for a same-cycle push.
  assign push = iq_if.dispatch_en && !full;
  assign pop  = iq_if.issue_valid && iq_if.exec_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
    assign snooped[gi] = valid_q[gi]
                       ? snoop(entries_q[gi], iq_if.cdb_valid, iq_if.cdb_tag, iq_if.cdb_data)
                       : entries_q[gi];
  end

  always_comb begin
    entries_d = snooped;
    valid_d   = valid_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        entries_d[rd_ptr_q] = '0;
        valid_d[rd_ptr_q]   = 1'b0;
        rd_ptr_d            = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        entries_d[wr_ptr_q] = snoop(iq_if.i_fifo_data, iq_if.cdb_valid,
                                    iq_if.cdb_tag, iq_if.cdb_data);
        valid_d[wr_ptr_q]   = 1'b1;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_common_issue_queue.sv
// Bench for common_issue_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the issue queue.
module tb_common_issue_queue;
  import common_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   fails  = 0;

  common_fifo_data_t model_q[$];

  common_issue_queue_if bus ();

  common_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .iq_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic common_fifo_data_t wake(input common_fifo_data_t e);
    common_fifo_data_t r;
    r = e;
    if (bus.cdb_valid) begin
      if (!r.rs1_data_valid && r.rs1_tag == bus.cdb_tag) begin
        r.rs1_data = bus.cdb_data; r.rs1_data_valid = 1'b1;
      end
      if (!r.rs2_data_valid && r.rs2_tag == bus.cdb_tag) begin
        r.rs2_data = bus.cdb_data; r.rs2_data_valid = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic common_fifo_data_t model_head();
    common_fifo_data_t h;
    h = '0;
    if (model_q.size() != 0) h = model_q[0];
    return h;
  endfunction

  function automatic logic model_ready();
    common_fifo_data_t h;
    h = model_head();
    return (model_q.size() != 0) && h.rs1_data_valid && h.rs2_data_valid;
  endfunction

  task automatic check_outputs();
    chk("queue_empty", bus.queue_empty, model_q.size() == 0);
    chk("queue_full", bus.queue_full, model_q.size() == DEPTH);
    chk("issue_valid", bus.issue_valid, model_ready());
    chk("o_issue_data", bus.o_issue_data, model_head());
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic pop, push;
    if (rst || flush) begin
      model_q.delete();
    end else begin
      pop  = model_ready() && bus.exec_ready;
      push = bus.dispatch_en && (model_q.size() < DEPTH);
      foreach (model_q[i]) model_q[i] = wake(model_q[i]);
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(wake(bus.i_fifo_data));
    end
  endtask

  task automatic tick();
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic er);
    bus.dispatch_en = 1'b0;
    bus.i_fifo_data = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_data    = '0;
    bus.exec_ready  = er;
    flush           = 1'b0;
    rst             = 1'b0;
  endtask

  function automatic common_fifo_data_t mk(input logic [5:0] t1, input logic v1,
                                           input logic [5:0] t2, input logic v2,
                                           input logic [5:0] rd);
    common_fifo_data_t e;
    e.wb_valid       = 1'($urandom_range(0, 1));
    e.rd_tag         = rd;
    e.rs1_tag        = t1;
    e.rs1_data       = v1 ? $urandom : 32'h0;
    e.rs1_data_valid = v1;
    e.rs2_tag        = t2;
    e.rs2_data       = v2 ? $urandom : 32'h0;
    e.rs2_data_valid = v2;
    return e;
  endfunction

  task automatic dispatch(input common_fifo_data_t e);
    bus.dispatch_en = 1'b1;
    bus.i_fifo_data = e;
  endtask

  initial begin
    common_fifo_data_t e;

    // Reset state
    idle(1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    chk("rst_empty", bus.queue_empty, 1'b1);
    chk("rst_full", bus.queue_full, 1'b0);
    chk("rst_issue_valid", bus.issue_valid, 1'b0);
    chk("rst_issue_data", bus.o_issue_data, '0);

    // 1: ready entry issues exactly once
    idle(1'b1); dispatch(mk(6'd1, 1'b1, 6'd2, 1'b1, 6'd10)); tick();
    idle(1'b1);
    chk("t1_issue_valid", bus.issue_valid, 1'b1);
    chk("t1_rd_tag", bus.o_issue_data.rd_tag, 6'd10);
    tick();
    chk("t1_empty_after", bus.queue_empty, 1'b1);
    chk("t1_no_reissue", bus.issue_valid, 1'b0);

    // 2: rs1 woken by a CDB broadcast two cycles after dispatch
    idle(1'b1); dispatch(mk(6'h05, 1'b0, 6'd7, 1'b1, 6'd11)); tick();
    idle(1'b1); tick();
    idle(1'b1); bus.cdb_valid = 1'b1; bus.cdb_tag = 6'h05; bus.cdb_data = 32'hDEADBEEF;
    chk("t2_not_ready", bus.issue_valid, 1'b0);
    tick();
    idle(1'b1);
    chk("t2_rs1_data", bus.o_issue_data.rs1_data, 32'hDEADBEEF);
    chk("t2_issue_valid", bus.issue_valid, 1'b1);
    tick();

    // 3: broadcast in the dispatch cycle is captured at enqueue
    idle(1'b1); dispatch(mk(6'h05, 1'b0, 6'd7, 1'b1, 6'd12));
    bus.cdb_valid = 1'b1; bus.cdb_tag = 6'h05; bus.cdb_data = 32'hDEADBEEF;
    tick();
    idle(1'b1);
    chk("t3_issue_valid", bus.issue_valid, 1'b1);
    chk("t3_rs1_data", bus.o_issue_data.rs1_data, 32'hDEADBEEF);
    tick();

    // 4: fill, drop a 5th dispatch, drain in order
    for (int i = 0; i < 4; i++) begin
      idle(1'b0); dispatch(mk(6'd1, 1'b1, 6'd2, 1'b1, 6'(20 + i))); tick();
    end
    chk("t4_full", bus.queue_full, 1'b1);
    idle(1'b0); dispatch(mk(6'd1, 1'b1, 6'd2, 1'b1, 6'd30)); tick();
    chk("t4_still_full", bus.queue_full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("t4_order", bus.o_issue_data.rd_tag, 6'(20 + i));
      tick();
    end
    chk("t4_empty", bus.queue_empty, 1'b1);

    // 5: ready younger entry waits behind a non-ready head
    idle(1'b1); dispatch(mk(6'd3, 1'b0, 6'd2, 1'b1, 6'd40)); tick();
    idle(1'b1); dispatch(mk(6'd1, 1'b1, 6'd2, 1'b1, 6'd41)); tick();
    idle(1'b1);
    chk("t5_blocked", bus.issue_valid, 1'b0);
    tick();
    idle(1'b1); bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd3; bus.cdb_data = 32'h1234_5678;
    tick();
    idle(1'b1);
    chk("t5_head_issue", bus.o_issue_data.rd_tag, 6'd40);
    chk("t5_head_valid", bus.issue_valid, 1'b1);
    tick();
    idle(1'b1);
    chk("t5_second_issue", bus.o_issue_data.rd_tag, 6'd41);
    tick();

    // 6: flush discards contents and a concurrent dispatch
    for (int i = 0; i < 3; i++) begin
      idle(1'b0); dispatch(mk(6'd1, 1'b1, 6'd2, 1'b1, 6'(50 + i))); tick();
    end
    idle(1'b1); flush = 1'b1; dispatch(mk(6'd1, 1'b1, 6'd2, 1'b1, 6'd60)); tick();
    chk("t6_empty", bus.queue_empty, 1'b1);
    chk("t6_issue_valid", bus.issue_valid, 1'b0);
    idle(1'b1); dispatch(mk(6'd1, 1'b1, 6'd2, 1'b1, 6'd61)); tick();
    idle(1'b1);
    chk("t6_post_flush", bus.o_issue_data.rd_tag, 6'd61);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      idle(1'($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 1) == 1) begin
        e = mk(6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               6'($urandom_range(0, 63)));
        dispatch(e);
      end
      if ($urandom_range(0, 9) < 4) begin
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'($urandom_range(0, 7));
        bus.cdb_data  = $urandom;
      end
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle(1'b0);
    check_outputs();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
